// File: rtl/pipearch_pkg.sv
// -----------------------------------------------------------------------------
// pipearch_pkg
//
// Shared definitions for the PipeArch operation sequencer:
//   OPCODE_W   - width of the instruction opcode field
//   REG_W      - width of one instruction register word
//   REPEAT_W   - width of the repeat count / iteration counter
//   t_seqstate - sequencer FSM state encoding
//   t_opcode   - operation unit opcodes (opcode k selects unit k)
//   norm_repeat() - maps a repeat count of 0 to 1
// -----------------------------------------------------------------------------
package pipearch_pkg;

    localparam int OPCODE_W = 4;
    localparam int REG_W    = 32;
    localparam int REPEAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } t_seqstate;

    typedef enum logic [OPCODE_W-1:0] {
        OP_COPY    = 4'd0,
        OP_COMPUTE = 4'd1,
        OP_SCATTER = 4'd2,
        OP_GATHER  = 4'd3
    } t_opcode;

    // A repeat count of zero still runs the operation once.
    function automatic logic [REPEAT_W-1:0] norm_repeat(input logic [REPEAT_W-1:0] r);
        return (r == '0) ? REPEAT_W'(1) : r;
    endfunction

endpackage

// File: rtl/pipearch_seq_watchdog.sv
// -----------------------------------------------------------------------------
// pipearch_seq_watchdog
//
// WAIT-state watchdog for the operation sequencer. Only built when
// PIPEARCH_SEQ_TIMEOUT_EN is defined; otherwise this file is empty.
//
// Parameters:
//   TIMEOUT_CYCLES - number of consecutive run cycles that trigger a timeout
// Ports:
//   clk     in  clock
//   reset   in  synchronous active-high reset
//   clear   in  restart the count (sequencer in START)
//   run     in  count this cycle (sequencer in WAIT)
//   timeout out high during the TIMEOUT_CYCLES-th consecutive run cycle
// -----------------------------------------------------------------------------
`ifdef PIPEARCH_SEQ_TIMEOUT_EN
module pipearch_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic timeout
);

    // Counter holds the number of run cycles already completed, so it only
    // needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (run && (cnt != LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Fires in the cycle that completes TIMEOUT_CYCLES run cycles.
    assign timeout = run && (cnt == LAST);

endmodule
`endif

// File: rtl/pipearch_op_sequencer.sv
// -----------------------------------------------------------------------------
// pipearch_op_sequencer
//
// Instruction sequencer for the PipeArch operation units. Accepts an
// instruction over valid/ready, decodes the opcode to one of NUM_UNITS units,
// broadcasts the register words, pulses that unit's op_start and waits for its
// op_done, repeating the operation instr_repeat times (0 treated as 1).
//
// Optional feature macro: PIPEARCH_SEQ_TIMEOUT_EN
//   When defined, a watchdog abandons an instruction whose unit does not
//   complete within TIMEOUT_CYCLES WAIT cycles and sets error.
//
// Parameters:
//   NUM_UNITS      - number of operation units (1..16)
//   NUM_REGS       - 32-bit register words per instruction
//   TIMEOUT_CYCLES - watchdog limit (only used with the macro)
// Ports:
//   clk           in   clock
//   reset         in   synchronous active-high reset
//   instr_valid   in   instruction available
//   instr_ready   out  sequencer accepts instruction (high in IDLE)
//   instr_opcode  in   target unit index
//   instr_regs    in   NUM_REGS x 32 register words
//   instr_repeat  in   execution count, 0 treated as 1
//   op_start      out  one-hot single-cycle start pulse
//   op_regs       out  latched register words shared by all units
//   op_done       in   per-unit single-cycle completion pulse
//   busy          out  high when not IDLE
//   num_completed out  completed unit executions, wraps mod 2^32
//   error         out  sticky error (invalid opcode or watchdog timeout)
// -----------------------------------------------------------------------------
module pipearch_op_sequencer
    import pipearch_pkg::*;
#(
    parameter int NUM_UNITS      = 4,
    parameter int NUM_REGS       = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [OPCODE_W-1:0]       instr_opcode,
    input  logic [NUM_REGS*REG_W-1:0] instr_regs,
    input  logic [REPEAT_W-1:0]       instr_repeat,
    output logic [NUM_UNITS-1:0]      op_start,
    output logic [NUM_REGS*REG_W-1:0] op_regs,
    input  logic [NUM_UNITS-1:0]      op_done,
    output logic                      busy,
    output logic [31:0]               num_completed,
    output logic                      error
);

    // Elaboration-time parameter sanity check.
    if (NUM_UNITS < 1 || NUM_UNITS > (1 << OPCODE_W) || NUM_REGS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("pipearch_op_sequencer: illegal parameter combination");
    end

    localparam logic [OPCODE_W:0] NUM_UNITS_V = (OPCODE_W + 1)'(NUM_UNITS);

    t_seqstate             state;
    logic [OPCODE_W-1:0]   opcode_q;
    logic [REPEAT_W-1:0]   repeat_q;
    logic [REPEAT_W-1:0]   iter_q;

    logic                  opcode_invalid;
    logic                  done_sel;
    logic                  last_iter;
    logic                  wd_timeout;

    assign opcode_invalid = ({1'b0, instr_opcode} >= NUM_UNITS_V);
    assign last_iter      = (iter_q == (repeat_q - REPEAT_W'(1)));

    // Start pulse and done selection are decoded from registered state and
    // opcode only, so op_start is glitch-free and at most one-hot.
    always_comb begin
        op_start = '0;
        done_sel = 1'b0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (opcode_q == OPCODE_W'(u)) begin
                op_start[u] = (state == ST_START);
                done_sel    = op_done[u];
            end
        end
    end

`ifdef PIPEARCH_SEQ_TIMEOUT_EN
    pipearch_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_START),
        .run     (state == ST_WAIT),
        .timeout (wd_timeout)
    );
`else
    assign wd_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            instr_ready   <= 1'b1;
            busy          <= 1'b0;
            opcode_q      <= '0;
            repeat_q      <= REPEAT_W'(1);
            iter_q        <= '0;
            op_regs       <= '0;
            num_completed <= '0;
            error         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        if (opcode_invalid) begin
                            // Consume and flag; nothing is latched or started.
                            error <= 1'b1;
                        end else begin
                            opcode_q    <= instr_opcode;
                            op_regs     <= instr_regs;
                            repeat_q    <= norm_repeat(instr_repeat);
                            // Clearing here is the single "first entry" into
                            // START for this instruction; repeats keep counting.
                            iter_q      <= '0;
                            state       <= ST_START;
                            instr_ready <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                end

                ST_START: begin
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // A done in the timeout cycle takes priority.
                    if (done_sel) begin
                        num_completed <= num_completed + 32'd1;
                        iter_q        <= iter_q + REPEAT_W'(1);
                        if (last_iter) begin
                            state       <= ST_IDLE;
                            instr_ready <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            state <= ST_START;
                        end
                    end else if (wd_timeout) begin
                        error       <= 1'b1;
                        state       <= ST_IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pipearch_op_sequencer.md
# pipearch_op_sequencer

Instruction sequencer for the PipeArch operation units (copy, compute, etc.). It accepts instructions from the instruction FIFO over a valid/ready handshake and decodes the opcode to select one of `NUM_UNITS` units. It broadcasts the instruction's register words, pulses that unit's `op_start`, and waits for its `op_done`, optionally repeating the operation. It sits between the instruction fetch path and the per-unit `op_start`/`op_done`/`regs` ports.

## Interface
- `NUM_UNITS`, 4: number of operation units; opcode `k` selects unit `k`.
- `NUM_REGS`, 2: 32-bit register words per instruction.
- `TIMEOUT_CYCLES`, 65535: watchdog limit (used only with the timeout macro).
- Clock and reset: reset `reset`, synchronous, active-high; clock `clk`.
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `instr_valid`  in  1  instruction available
- `instr_ready`  out  1  sequencer accepts instruction
- `instr_opcode`  in  4  target unit index
- `instr_regs`  in  `NUM_REGS`×32  register words for the unit
- `instr_repeat`  in  16  number of executions; 0 treated as 1
- `op_start`  out  `NUM_UNITS`  one-hot, single-cycle start pulse
- `op_regs`  out  `NUM_REGS`×32  latched register words, shared by all units
- `op_done`  in  `NUM_UNITS`  per-unit single-cycle completion pulse
- `busy`  out  1  high when not in IDLE
- `num_completed`  out  32  count of completed unit executions
- `error`  out  1  sticky error flag

## Operation
- States: `IDLE`, `START`, `WAIT`.
- IDLE:
  - `instr_ready`=1. On `instr_valid`&&`instr_ready`, latch opcode, regs, and `repeat` (0→1), then go to START.
  - If opcode ≥ `NUM_UNITS`: consume the instruction, set `error`, stay in IDLE.
- START:
  - `op_start[opcode]`=1 for exactly this cycle; every other bit is 0.
  - Clear the iteration counter only on the first entry per instruction. Go to WAIT.
- WAIT:
  - Sample only `op_done[opcode]`. Pulses from other units are ignored.
  - On done: `num_completed`+1 and iteration+1. If iteration == repeat−1, go to IDLE; otherwise go to START.
- `op_regs` holds its value from acceptance until the next acceptance. It never changes while `busy`.
- Iteration counter is 16 bits. `num_completed` wraps modulo 2^32.

## Timing
- Reset values: state IDLE, `instr_ready`=1, `op_start`=0, `op_regs`=0, `busy`=0, `num_completed`=0, `error`=0.
- `op_start` is decoded combinationally from the registered state and opcode. It is glitch-free and never multi-hot.
- Instruction accepted at cycle T: `op_start` is high at T+1, and WAIT runs from T+2.
- `op_done` accepted at cycle D:
  - If repeating: `op_start` again at D+1.
  - If final: IDLE at D+1 with `instr_ready`=1 and `busy`=0. The earliest next start is D+2.
- `op_done` is sampled only in WAIT. A done asserted during START is lost; units must not assert done in the start cycle.
- Reset mid-operation: return to IDLE immediately and clear all counters and `error`. The units are reset by the same `reset`.

## Configuration
- `PIPEARCH_SEQ_TIMEOUT_EN` defined:
  - A watchdog counter runs in WAIT and clears on every entry to START.
  - If it reaches `TIMEOUT_CYCLES` with no done: set `error`, abandon the remaining repeats, go to IDLE, and leave `num_completed` unchanged.
  - A done arriving in the same cycle as the timeout wins; no error is raised.
- Undefined: no counter exists, WAIT lasts indefinitely, and `error` comes only from an invalid opcode.

## Structure
- The shared package `pipearch_pkg` holds `t_seqstate`, the opcode width constant (4), and the opcode enumeration (e.g. `OP_COPY`=0).
- The sub-module `pipearch_seq_watchdog` (counter, clear, timeout pulse) is instantiated only under `PIPEARCH_SEQ_TIMEOUT_EN`.

## Test plan
- Opcode 0, repeat 1, regs {0x0004_0000, 0x0008_0000}; unit 0 done 10 cycles after start → one `op_start[0]` pulse at T+1, `op_regs` stable throughout, `num_completed`=1, `instr_ready` back high after the done cycle.
- Opcode 2, repeat 3 → three `op_start[2]` pulses, each one cycle after the previous done; `num_completed`=3; `busy` stays high until after the third done.
- Opcode 1 in WAIT while spurious `op_done[0]` and `op_done[3]` pulse → ignored; completion only on `op_done[1]`.
- Opcode 7 with `NUM_UNITS`=4 → instruction consumed, `error`=1, no `op_start`; the following valid instruction still executes.
- Reset asserted two cycles into WAIT with repeat 5 → next cycle IDLE, all outputs at reset values, no further `op_start`.
- With `PIPEARCH_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, unit never completes → `error`=1 after 16 WAIT cycles, IDLE, `num_completed` unchanged; a done coinciding with cycle 16 → no error.
